// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for a 5-stage MIPS-style pipeline.
// One 32-iteration operation at a time; MT/MF moves complete in a single cycle.
module mult_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        start,
   input  logic [5:0]  funct,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        stall,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] work_q, work_d;
   logic [31:0] opnd_q, opnd_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        div0_q, div0_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        op_signed_s, op_is_div_s, a_neg_s, b_neg_s;
   logic [31:0] a_mag_s, b_mag_s;
   logic [32:0] mul_sum_s;
   logic [63:0] mul_next_s;
   logic [33:0] div_diff_s;
   logic [63:0] div_next_s;
   logic [63:0] mul_fin_s;
   logic [31:0] fin_hi_s, fin_lo_s;

   // Operand decode: signedness and magnitudes latched on acceptance
   always_comb begin
      op_signed_s = (funct == F_MULT) || (funct == F_DIV);
      op_is_div_s = (funct == F_DIV) || (funct == F_DIVU);
      a_neg_s     = op_signed_s & op_a[31];
      b_neg_s     = op_signed_s & op_b[31];
      a_mag_s     = a_neg_s ? (32'd0 - op_a) : op_a;
      b_mag_s     = b_neg_s ? (32'd0 - op_b) : op_b;
   end

   // One iteration step; work_q holds {acc, multiplier} or {remainder, quotient}
   always_comb begin
      mul_sum_s  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
      mul_next_s = {mul_sum_s, work_q[31:1]};
      div_diff_s = {1'b0, work_q[63:31]} - {2'b00, opnd_q};
      div_next_s = div_diff_s[33] ? {work_q[62:0], 1'b0}
                                  : {div_diff_s[31:0], work_q[30:0], 1'b1};
   end

   // Sign fix-up of the magnitude result; divide-by-zero leaves hi = dividend
   always_comb begin
      mul_fin_s = neg_res_q ? (64'd0 - work_q) : work_q;
      if (is_div_q) begin
         fin_hi_s = neg_rem_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
         if (div0_q) begin
            fin_lo_s = 32'hFFFF_FFFF;
         end else begin
            fin_lo_s = neg_res_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
         end
      end else begin
         fin_hi_s = mul_fin_s[63:32];
         fin_lo_s = mul_fin_s[31:0];
      end
   end

   // Next-state, datapath updates and pipeline handshake outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      stall     = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush || !start) begin
               state_d = S_IDLE;
            end else begin
               case (funct)
                  F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                     stall     = 1'b1;
                     state_d   = S_BUSY;
                     cnt_d     = 6'd32;
                     is_div_d  = op_is_div_s;
                     opnd_d    = op_is_div_s ? b_mag_s : a_mag_s;
                     work_d    = {32'd0, (op_is_div_s ? a_mag_s : b_mag_s)};
                     neg_res_d = a_neg_s ^ b_neg_s;
                     neg_rem_d = a_neg_s;
                     div0_d    = (op_b == 32'd0);
                  end
                  F_MTHI:  hi_d = op_a;
                  F_MTLO:  lo_d = op_a;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_BUSY: begin
            stall  = 1'b1;
            work_d = is_div_q ? div_next_s : mul_next_s;
            cnt_d  = cnt_q - 6'd1;
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = 6'd0;
            end else if (cnt_q == 6'd1) begin
               state_d = S_DONE;
            end else begin
               state_d = S_BUSY;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (flush) begin
               done = 1'b0;
            end else begin
               done = 1'b1;
               hi_d = fin_hi_s;
               lo_d = fin_lo_s;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
         end
      endcase
   end

   // MFHI/MFLO read port
   always_comb begin
      case (funct)
         F_MFHI:  result = hi_q;
         F_MFLO:  result = lo_q;
         default: result = 32'd0;
      endcase
   end

   // State and architectural register update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         work_q    <= 64'd0;
         opnd_q    <= 32'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: MultDiv

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose: flush  input  1  abort the EX-stage instruction, active-high.
REQ-004 SHALL expose: start  input  1  valid EX-stage instruction present.
REQ-005 SHALL expose: funct  input  6  ALU function code from the ID-stage funct generator.
REQ-006 SHALL expose: op_a  input  32  rs operand (dividend / multiplicand / MT source).
REQ-007 SHALL expose: op_b  input  32  rt operand (divisor / multiplier).
REQ-008 SHALL expose: stall  output  1  hold the pipeline upstream of EX.
REQ-009 SHALL expose: done  output  1  one-cycle completion pulse for MULT/MULTU/DIV/DIVU.
REQ-010 SHALL expose: result  output  32  MFHI/MFLO read data; 0 for all other funct.
REQ-011 SHALL expose: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL decode funct: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B; any other code is ignored.
REQ-013 SHALL implement states IDLE, BUSY and DONE, with a 6-bit iteration counter.
REQ-014 SHALL accept an operation only when state=IDLE, start=1, flush=0 and funct is MULT/MULTU/DIV/DIVU; the next state is BUSY, the counter is loaded with 32, and operand magnitudes, sign flags and op type are latched.
REQ-015 SHALL perform one iteration per BUSY cycle: shift-add for multiply, restoring shift-subtract for divide; the counter decrements, and at 0 the next state is DONE.
REQ-016 SHALL hold done=1 during DONE only, write hi/lo on the DONE->IDLE edge, and return to IDLE unconditionally.
REQ-017 SHALL drive stall combinationally as 1 in the acceptance cycle and in every BUSY cycle, and 0 in IDLE (no acceptance) and in DONE.
REQ-018 SHALL meet a latency of acceptance cycle N, BUSY N+1..N+32, DONE N+33, hi/lo visible from N+34.
REQ-019 SHALL produce, for MULT/MULTU, the 64-bit product {hi,lo}; MULT is a signed two's-complement product and MULTU is unsigned.
REQ-020 SHALL produce, for DIV/DIVU, lo=quotient and hi=remainder; for DIV the quotient is negated when operand signs differ and the remainder takes the dividend's sign.
REQ-021 SHALL handle divide-by-zero (op_b=0, DIV or DIVU) by still taking 34 cycles and writing lo=0xFFFFFFFF, hi=op_a.
REQ-022 SHALL handle DIV 0x80000000 / 0xFFFFFFFF by writing lo=0x80000000, hi=0.
REQ-023 SHALL write MTHI/MTLO data to hi/lo on the clock edge when state=IDLE, start=1 and flush=0, with stall=0.
REQ-024 SHALL drive result for MFHI/MFLO combinationally from the current hi/lo, with stall=0 when state=IDLE.
REQ-025 SHALL treat start=1 while BUSY or DONE as the same stalled instruction, with no re-acceptance.
REQ-026 SHALL, when flush=1 in any state, force state to IDLE on the next edge, leave hi/lo unchanged, suppress done, and give flush priority over a simultaneous acceptance or MT write.

Reset
REQ-027 SHALL, on asynchronous rst=1, immediately set state=IDLE, counter=0, hi=lo=0 and done=0; stall follows its combinational rule.
REQ-028 SHALL, on reset mid-operation, discard the in-flight operation without writing hi/lo.

Verification
REQ-029 SHALL cover MULT: op_a=0xFFFFFFFE, op_b=0x00000003 -> done at cycle N+33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall high for N..N+32.
REQ-030 SHALL cover DIVU and DIV: DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 SHALL cover the division edge cases: DIV by 0 with op_a=0x1234 -> lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL cover flush and mid-operation reset: flush at BUSY cycle N+10 -> state IDLE at N+11, hi/lo unchanged, no done pulse; rst pulse at N+5 -> hi=lo=0 immediately.
REQ-033 SHALL cover MT/MF: MTLO 0xCAFEBABE then MFLO -> result=0xCAFEBABE with no stall; MULTU immediately followed by MFHI -> MFHI reads the new hi at N+34.
